icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 159 +++++++++++++++
 tb/tb_icache.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache, 4-word lines, flip-flop storage.
// Misses refill the whole line word by word from backing memory, then respond.
module icache #(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iread_ce,
    input  logic [31:0] iram_addr,
    output logic [31:0] ram_inst,
    output logic        irom_fin,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 32 - INDEX_BITS - 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [31:0]           r_data [LINES][4];

    logic [TAG_W-1:0]      r_req_tag;
    logic [INDEX_BITS-1:0] r_req_idx;
    logic [1:0]            r_req_off;
    logic [1:0]            r_cnt;
    logic                  r_inv_pend;
    logic [31:0]           r_word;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_idx;
    logic [1:0]            w_off;
    logic                  w_hit;
    logic                  w_fill;
    logic                  w_fill_last;
    logic                  w_unused_addr_lsbs;

    assign w_tag              = iram_addr[31:INDEX_BITS+4];
    assign w_idx              = iram_addr[INDEX_BITS+3:4];
    assign w_off              = iram_addr[3:2];
    assign w_unused_addr_lsbs = ^iram_addr[1:0];
    assign w_hit              = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill             = (r_state == S_REFILL) && mem_valid;
    assign w_fill_last        = w_fill && (r_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (iread_ce) begin
                    w_next = (w_hit && !inv) ? S_RESP : S_REFILL;
                end
            end
            S_REFILL: begin
                if (w_fill_last) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= '0;
            r_cnt      <= '0;
            r_inv_pend <= 1'b0;
            r_word     <= '0;
            r_req_tag  <= '0;
            r_req_idx  <= '0;
            r_req_off  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inv) begin
                        r_valid <= '0;
                    end
                    if (iread_ce) begin
                        if (w_hit && !inv) begin
                            r_word <= r_data[w_idx][w_off];
                        end else begin
                            r_req_tag  <= w_tag;
                            r_req_idx  <= w_idx;
                            r_req_off  <= w_off;
                            r_cnt      <= '0;
                            r_inv_pend <= 1'b0;
                        end
                    end
                end
                S_REFILL: begin
                    if (inv) begin
                        r_inv_pend <= 1'b1;
                    end
                    if (mem_valid) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            // Earlier words are already in the array; the last one is only on the bus.
                            r_word <= (r_cnt == r_req_off) ? mem_rdata
                                                           : r_data[r_req_idx][r_req_off];
                            if (r_inv_pend || inv) begin
                                r_valid <= '0;
                            end else begin
                                r_valid[r_req_idx] <= 1'b1;
                            end
                            r_inv_pend <= 1'b0;
                        end
                    end
                end
                S_RESP: begin
                    if (inv) begin
                        r_valid <= '0;
                    end
                end
                default: begin
                    r_valid <= '0;
                end
            endcase
        end
    end

    // Data and tag arrays carry no reset; validity alone guards them.
    always_ff @(posedge clk) begin
        if (rst && w_fill) begin
            r_data[r_req_idx][r_cnt] <= mem_rdata;
        end
        if (rst && w_fill_last) begin
            r_tag[r_req_idx] <= r_req_tag;
        end
    end

    always_comb begin
        mem_req  = (r_state == S_REFILL);
        mem_addr = mem_req ? {r_req_tag, r_req_idx, r_cnt, 2'b00} : '0;
        irom_fin = (r_state == S_RESP);
        ram_inst = irom_fin ? r_word : '0;
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: transaction-level cache model, per-cycle output
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_icache;

    localparam int unsigned IB    = 4;
    localparam int unsigned LINES = 16;

    logic        clk;
    logic        rst;
    logic        iread_ce;
    logic [31:0] iram_addr;
    logic [31:0] ram_inst;
    logic        irom_fin;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    icache #(.INDEX_BITS(IB)) dut (
        .clk      (clk),
        .rst      (rst),
        .iread_ce (iread_ce),
        .iram_addr(iram_addr),
        .ram_inst (ram_inst),
        .irom_fin (irom_fin),
        .inv      (inv),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of cache contents: what the cache must hold after each transaction.
    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];
    logic [31:0] mdata  [LINES][4];

    logic [31:0] exp_inst, exp_addr;
    logic        exp_fin, exp_req;
    bit          cmp_en;
    int          n_chk, n_fail;

    int unsigned epoch;
    bit          directed;
    logic [31:0] dir_base;
    logic [31:0] log_addr[$];
    logic [31:0] last_inst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("irom_fin", {31'd0, irom_fin}, {31'd0, exp_fin});
            chk("ram_inst", ram_inst, exp_inst);
            chk("mem_req",  {31'd0, mem_req},  {31'd0, exp_req});
            chk("mem_addr", mem_addr, exp_addr);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_fin  = 1'b0;
        exp_inst = '0;
        exp_req  = 1'b0;
        exp_addr = '0;
    endtask

    task automatic model_inv_all();
        for (int i = 0; i < LINES; i++) mvalid[i] = 0;
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a, input int k);
        if (directed) return dir_base + 32'(k);
        return (a * 32'h9E37_79B1) ^ (32'(epoch) << 16) ^ 32'h0000_1357;
    endfunction

    task automatic idle_cycles(input int n, input bit allow_inv);
        for (int c = 0; c < n; c++) begin
            iread_ce  = 1'b0;
            mem_valid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            inv       = allow_inv && ($urandom_range(0, 7) == 0);
            if (inv) model_inv_all();
            exp_idle();
            step();
            inv = 1'b0;
        end
    endtask

    // inv_mode: 0 none, 1 inv with the request, 2 inv during refill, 3 inv in response cycle.
    // abort_after >= 0: reset after that many refill words were accepted.
    task automatic fetch(input logic [31:0] a, input int gap_pct, input int inv_mode,
                         input int abort_after);
        int          idx, off, k, gaps;
        logic [31:0] tag;
        bit          hit, invp, v;
        logic [31:0] words[4];

        idx = int'(a[7:4]);
        off = int'(a[3:2]);
        tag = a >> 8;
        log_addr.delete();

        iread_ce  = 1'b1;
        iram_addr = a;
        inv       = (inv_mode == 1);
        mem_valid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        exp_idle();
        if (inv_mode == 1) model_inv_all();
        hit = mvalid[idx] && (mtag[idx] == tag);
        step();
        inv = 1'b0;

        if (hit) begin
            exp_fin   = 1'b1;
            exp_inst  = mdata[idx][off];
            mem_valid = 1'($urandom_range(0, 1));
            last_inst = ram_inst;
        end else begin
            epoch++;
            k    = 0;
            gaps = 0;
            invp = 0;
            while (k < 4) begin
                exp_fin  = 1'b0;
                exp_inst = '0;
                exp_req  = 1'b1;
                exp_addr = {a[31:4], 2'(k), 2'b00};
                if (abort_after >= 0 && k == abort_after) begin
                    rst       = 1'b0;
                    mem_valid = 1'b1;
                    mem_rdata = $urandom;
                    step();
                    rst = 1'b1;
                    model_inv_all();
                    exp_idle();
                    chk("abort_req", {31'd0, mem_req}, 32'd0);
                    iread_ce  = 1'b0;
                    mem_valid = 1'b1;
                    mem_rdata = $urandom;
                    step();
                    exp_idle();
                    mem_valid = 1'b0;
                    return;
                end
                iram_addr = $urandom;
                v         = (gaps >= 3) || ($urandom_range(0, 99) >= gap_pct);
                mem_valid = v;
                mem_rdata = v ? memword(exp_addr, k) : $urandom;
                inv       = (inv_mode == 2) && ((k == 2 && !invp) || $urandom_range(0, 5) == 0);
                invp      = invp | inv;
                if (v) begin
                    log_addr.push_back(mem_addr);
                    words[k] = mem_rdata;
                end
                step();
                inv = 1'b0;
                if (v) begin
                    k++;
                    gaps = 0;
                end else begin
                    gaps++;
                end
            end
            mvalid[idx] = 1;
            mtag[idx]   = tag;
            for (int w = 0; w < 4; w++) mdata[idx][w] = words[w];
            if (invp) model_inv_all();
            exp_fin   = 1'b1;
            exp_inst  = words[off];
            exp_req   = 1'b0;
            exp_addr  = '0;
            mem_valid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            last_inst = ram_inst;
        end

        // Request stays asserted through the response; it must not be remembered.
        iram_addr = a;
        inv       = (inv_mode == 3);
        if (inv) model_inv_all();
        step();
        inv       = 1'b0;
        iread_ce  = 1'b0;
        mem_valid = 1'b0;
        exp_idle();
    endtask

    task automatic chk_log(input string nm, input logic [31:0] base);
        chk({nm, "_nwords"}, 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < log_addr.size(); i++)
            chk({nm, "_addr"}, log_addr[i], base + 32'(4 * i));
    endtask

    initial begin
        rst       = 1'b0;
        iread_ce  = 1'b0;
        iram_addr = '0;
        inv       = 1'b0;
        mem_rdata = '0;
        mem_valid = 1'b0;
        n_chk     = 0;
        n_fail    = 0;
        epoch     = 0;
        cmp_en    = 0;
        model_inv_all();
        step();
        exp_idle();
        cmp_en = 1;
        chk("reset_fin",  {31'd0, irom_fin}, 32'd0);
        chk("reset_req",  {31'd0, mem_req},  32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_inst", ram_inst, 32'd0);
        mem_valid = 1'b1;
        step();
        rst = 1'b1;
        idle_cycles(2, 0);

        directed = 1;
        dir_base = 32'hA0;
        fetch(32'h0000_0104, 0, 0, -1);
        chk_log("cold", 32'h0000_0100);
        chk("cold_inst", last_inst, 32'hA1);
        fetch(32'h0000_010C, 0, 0, -1);
        chk("hit_nwords", 32'(log_addr.size()), 32'd0);
        chk("hit_inst", last_inst, 32'hA3);

        dir_base = 32'hB0;
        fetch(32'h0000_1104, 0, 0, -1);
        chk_log("conflict", 32'h0000_1100);
        chk("conflict_inst", last_inst, 32'hB1);
        dir_base = 32'hC0;
        fetch(32'h0000_0104, 0, 0, -1);
        chk_log("evicted", 32'h0000_0100);
        chk("evicted_inst", last_inst, 32'hC1);

        dir_base = 32'hD0;
        fetch(32'h0000_2208, 60, 0, -1);
        chk_log("gapped", 32'h0000_2200);
        chk("gapped_inst", last_inst, 32'hD2);
        fetch(32'h0000_2200, 0, 0, -1);
        chk("gapped_hit_inst", last_inst, 32'hD0);

        dir_base = 32'hE0;
        fetch(32'h0000_3304, 30, 2, -1);
        chk("invrefill_inst", last_inst, 32'hE1);
        fetch(32'h0000_3304, 0, 0, -1);
        chk("invrefill_refetch_nwords", 32'(log_addr.size()), 32'd4);

        dir_base = 32'hF0;
        fetch(32'h0000_4400, 0, 0, 2);
        idle_cycles(1, 0);
        fetch(32'h0000_4400, 0, 0, -1);
        chk("abort_refetch_nwords", 32'(log_addr.size()), 32'd4);
        chk("abort_refetch_inst", last_inst, 32'hF0);
        fetch(32'h0000_4400, 0, 1, -1);
        chk("inv_with_req_nwords", 32'(log_addr.size()), 32'd4);

        directed = 0;
        for (int it = 0; it < 300; it++) begin
            logic [31:0] tg, a;
            int r, ab;
            case ($urandom_range(0, 3))
                0:       tg = 32'h0;
                1:       tg = 32'h1;
                2:       tg = 32'hFF_FFFF;
                default: tg = 32'hAB_CDE1;
            endcase
            a  = (tg << 8) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            r  = $urandom_range(0, 99);
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
            fetch(a, $urandom_range(0, 70), (r < 8) ? 1 : (r < 16) ? 2 : (r < 22) ? 3 : 0, ab);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1);
        end

        idle_cycles(2, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
